// File: rtl/mono_rx_fifo_arbiter_if.sv
// mono_rx_fifo_arbiter_if
//   Bundle of the source-side FIFO handshake, the downstream output slot,
//   the static enable mask and the status outputs of the receiver FIFO
//   arbiter. Clock and reset are kept outside as plain ports.
//
//   Signals (direction as seen by the arbiter, i.e. the slave modport):
//     SRC_EMPTY    in   N_SRC     per-source FIFO empty flag
//     SRC_DATA     in   32*N_SRC  per-source head word, source i at [32*i+31:32*i]
//     SRC_READ     out  N_SRC     per-source pop strobe (combinational)
//     CONF_EN_MASK in   N_SRC     per-source enable
//     OUT_READ     in   1         downstream pop of the held output word
//     OUT_EMPTY    out  1         no output word held
//     OUT_DATA     out  32        held output word
//     GRANT_VALID  out  1         a burst grant is active
//     GRANT_IDX    out  3         index of the granted source
//     WORD_CNT     out  32        saturating count of words transferred
interface mono_rx_fifo_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]    SRC_EMPTY;
    logic [32*N_SRC-1:0] SRC_DATA;
    logic [N_SRC-1:0]    SRC_READ;
    logic [N_SRC-1:0]    CONF_EN_MASK;
    logic                OUT_READ;
    logic                OUT_EMPTY;
    logic [31:0]         OUT_DATA;
    logic                GRANT_VALID;
    logic [2:0]          GRANT_IDX;
    logic [31:0]         WORD_CNT;

    // Arbiter side.
    modport slave (
        input  SRC_EMPTY,
        input  SRC_DATA,
        input  CONF_EN_MASK,
        input  OUT_READ,
        output SRC_READ,
        output OUT_EMPTY,
        output OUT_DATA,
        output GRANT_VALID,
        output GRANT_IDX,
        output WORD_CNT
    );

    // Environment side: source FIFOs, configuration and downstream consumer.
    modport master (
        output SRC_EMPTY,
        output SRC_DATA,
        output CONF_EN_MASK,
        output OUT_READ,
        input  SRC_READ,
        input  OUT_EMPTY,
        input  OUT_DATA,
        input  GRANT_VALID,
        input  GRANT_IDX,
        input  WORD_CNT
    );
endinterface

// File: rtl/mono_rx_fifo_arbiter.sv
// mono_rx_fifo_arbiter
//   Round-robin burst arbiter that merges N_SRC receiver FIFOs into a single
//   one-word output slot. A source is granted for up to MAX_BURST words; the
//   grant is dropped early when the source empties or is disabled. After each
//   grant the search pointer moves one past the granted source, so every
//   continuously eligible source is served within N_SRC-1 other grants.
//
//   Ports:
//     BUS_CLK  in   single clock, rising edge
//     BUS_RST  in   synchronous active-high reset
//     bus      mono_rx_fifo_arbiter_if.slave (FIFO handshake, output slot,
//              enable mask, grant status, word counter)
module mono_rx_fifo_arbiter #(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RST,
    mono_rx_fifo_arbiter_if.slave       bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  grant_idx;
    logic [2:0]  ptr;
    logic [7:0]  burst_cnt;
    logic        out_empty;
    logic [31:0] out_data;
    logic [31:0] word_cnt;

    logic [N_SRC-1:0] eligible;
    logic             any_elig;
    logic             grant_elig;
    logic [31:0]      grant_data;
    logic             found_hi;
    logic             found_lo;
    logic [2:0]       pick_hi;
    logic [2:0]       pick_lo;
    logic [2:0]       pick;
    logic             slot_free;
    logic             xfer;
    logic [2:0]       next_ptr;
    logic             last_word;

    always_comb begin
        eligible = bus.CONF_EN_MASK & ~bus.SRC_EMPTY;
        any_elig = |eligible;

        // Per-source mux for the granted source's flag and head word.
        grant_elig = 1'b0;
        grant_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (3'(i) == grant_idx) begin
                grant_elig = eligible[i];
                grant_data = bus.SRC_DATA[32*i +: 32];
            end
        end

        // Circular search from ptr: the first eligible index at or above ptr
        // wins; otherwise wrap around to the lowest eligible index.
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (eligible[i] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = 3'(i);
            end
            if (eligible[i] && !found_hi && (3'(i) >= ptr)) begin
                found_hi = 1'b1;
                pick_hi  = 3'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;

        slot_free = out_empty | bus.OUT_READ;
        // Reset gates the pop strobe so no word leaves a source FIFO while
        // the output slot is being discarded.
        xfer      = (state == BURST) && grant_elig && slot_free && !BUS_RST;
        next_ptr  = (grant_idx == 3'(N_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
        last_word = (burst_cnt == 8'(MAX_BURST - 1));

        bus.SRC_READ = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (xfer && (3'(i) == grant_idx)) begin
                bus.SRC_READ[i] = 1'b1;
            end
        end

        bus.OUT_EMPTY   = out_empty;
        bus.OUT_DATA    = out_data;
        bus.GRANT_VALID = (state == BURST);
        bus.GRANT_IDX   = grant_idx;
        bus.WORD_CNT    = word_cnt;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= IDLE;
            grant_idx <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            out_empty <= 1'b1;
            out_data  <= '0;
            word_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant_idx <= pick;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!grant_elig) begin
                        // Source emptied or was disabled: release at once.
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end else if (xfer) begin
                        if (last_word) begin
                            state <= IDLE;
                            ptr   <= next_ptr;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                    // Eligible but slot full: hold the grant and wait.
                end
                default: state <= IDLE;
            endcase

            // A transfer refills the slot even when it is popped in the same
            // cycle, so a streaming consumer sees no bubble.
            if (xfer) begin
                out_data  <= grant_data;
                out_empty <= 1'b0;
                if (word_cnt != '1) begin
                    word_cnt <= word_cnt + 32'd1;
                end
            end else if (bus.OUT_READ) begin
                out_empty <= 1'b1;
            end
        end
    end

endmodule
